// File: rtl/winograd_tile_feeder_if.sv
// Pixel-in / tile-out handshake bundle for the Winograd tile feeder.
// The feeder uses the slave view; the pixel source and tile sink use the master view.
interface winograd_tile_feeder_if #(
  parameter int PIX_W  = 24,
  parameter int TILE_W = 384,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_pixel;
  logic              tile_valid;
  logic              tile_ready;
  logic [TILE_W-1:0] tile_data;
  logic [IDX_W-1:0]  tile_row;
  logic [IDX_W-1:0]  tile_col;
  logic              last_tile;

  modport master (
    output in_valid, in_pixel, tile_ready,
    input  in_ready, tile_valid, tile_data, tile_row, tile_col, last_tile
  );

  modport slave (
    input  in_valid, in_pixel, tile_ready,
    output in_ready, tile_valid, tile_data, tile_row, tile_col, last_tile
  );
endinterface

// File: rtl/winograd_tile_feeder.sv
// Buffers T raster rows in a circular line buffer and emits overlapping TxT tiles
// (stride T-K+1) to the Winograd PE; filling and emitting never overlap.
module winograd_tile_feeder #(
  parameter int KERNEL_SIZE      = 3,
  parameter int INPUT_TILE_SIZE  = 4,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CHANNELS         = 3,
  parameter int IMG_WIDTH        = 8,
  parameter int IMG_HEIGHT       = 8,
  parameter int IDX_W            = 8
) (
  input  logic clk,
  input  logic reset,
  winograd_tile_feeder_if.slave feed_if
);

  localparam int T      = INPUT_TILE_SIZE;
  localparam int W      = INPUT_DATA_WIDTH;
  localparam int C      = CHANNELS;
  localparam int S      = T - KERNEL_SIZE + 1;
  localparam int PIX_W  = W * C;
  localparam int TILE_W = T * T * W * C;
  localparam int TR     = (IMG_WIDTH - T) / S + 1;
  localparam int TB     = (IMG_HEIGHT - T) / S + 1;
  localparam int XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW     = (T > 1) ? $clog2(T) : 1;
  localparam int CW     = $clog2(T + 1);

  localparam logic [XW-1:0]    LAST_X    = XW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]    LAST_ROW  = RW'(T - 1);
  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(TR - 1);
  localparam logic [IDX_W-1:0] LAST_BAND = IDX_W'(TB - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t            state_q;
  logic [XW-1:0]     x_q;
  logic [RW-1:0]     wr_row_q;
  logic [CW-1:0]     rows_q;
  logic [IDX_W-1:0]  band_q;
  logic [IDX_W-1:0]  tile_row_q;
  logic [IDX_W-1:0]  tile_col_q;
  logic              tile_valid_q;
  logic              last_q;
  logic              in_ready_q;
  logic [TILE_W-1:0] tile_data_q;

  logic [PIX_W-1:0]  lb_q [T][IMG_WIDTH];

  logic              accept;
  logic [CW-1:0]     rows_need;
  logic [IDX_W-1:0]  col_d;
  logic [TILE_W-1:0] tile_data_d;
  logic [RW-1:0]     rd_row [T];
  logic [XW-1:0]     rd_col [T];

  assign accept    = feed_if.in_valid && in_ready_q;
  assign rows_need = (band_q == '0) ? CW'(T) : CW'(S);
  assign col_d     = (state_q == S_LOAD) ? '0 : tile_col_q + 1'b1;

  // Once a fill completes, the write pointer points at the oldest buffered row.
  for (genvar r = 0; r < T; r++) begin : g_rd_row
    assign rd_row[r] = RW'((32'(wr_row_q) + r) % T);
  end

  for (genvar k = 0; k < T; k++) begin : g_rd_col
    assign rd_col[k] = XW'(32'(col_d) * S + k);
  end

  for (genvar c = 0; c < C; c++) begin : g_ch
    for (genvar r = 0; r < T; r++) begin : g_row
      for (genvar k = 0; k < T; k++) begin : g_col
        assign tile_data_d[((c * T + r) * T + k) * W +: W] = lb_q[rd_row[r]][rd_col[k]][c * W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[wr_row_q][x_q] <= feed_if.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      x_q          <= '0;
      wr_row_q     <= '0;
      rows_q       <= '0;
      band_q       <= '0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
      tile_valid_q <= 1'b0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      tile_data_q  <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            if (x_q == LAST_X) begin
              x_q      <= '0;
              wr_row_q <= (wr_row_q == LAST_ROW) ? '0 : wr_row_q + 1'b1;
              if (rows_q + 1'b1 == rows_need) begin
                rows_q     <= '0;
                in_ready_q <= 1'b0;
                state_q    <= S_LOAD;
              end else begin
                rows_q <= rows_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        // One cycle for the final pixel of the fill to land before the first tile is read.
        S_LOAD: begin
          tile_data_q  <= tile_data_d;
          tile_row_q   <= band_q;
          tile_col_q   <= '0;
          tile_valid_q <= 1'b1;
          last_q       <= (band_q == LAST_BAND) && (LAST_COL == '0);
          state_q      <= S_EMIT;
        end
        S_EMIT: begin
          if (feed_if.tile_ready) begin
            if (tile_col_q == LAST_COL) begin
              tile_valid_q <= 1'b0;
              last_q       <= 1'b0;
              in_ready_q   <= 1'b1;
              band_q       <= (band_q == LAST_BAND) ? '0 : band_q + 1'b1;
              state_q      <= S_FILL;
            end else begin
              tile_col_q  <= col_d;
              tile_data_q <= tile_data_d;
              last_q      <= (band_q == LAST_BAND) && (col_d == LAST_COL);
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign feed_if.in_ready   = in_ready_q;
  assign feed_if.tile_valid = tile_valid_q;
  assign feed_if.tile_data  = tile_data_q;
  assign feed_if.tile_row   = tile_row_q;
  assign feed_if.tile_col   = tile_col_q;
  assign feed_if.last_tile  = last_q;

endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Directed bench for winograd_tile_feeder: 8x8x3 frames with pixel(y,x,c) = y*8+x+1+64*c (+frame).
module tb_winograd_tile_feeder;
  localparam int T      = 4;
  localparam int W      = 8;
  localparam int PIX_W  = 24;
  localparam int TILE_W = 384;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   overlap_cnt = 0;
  int   first_valid_edge = -1;
  int   acc32_edge = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  winograd_tile_feeder_if #(.PIX_W(PIX_W), .TILE_W(TILE_W), .IDX_W(8)) fi ();

  winograd_tile_feeder dut (
    .clk     (clk),
    .reset   (reset),
    .feed_if (fi)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish within 60000 cycles");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] pix(input int f, input int y, input int x, input int c);
    return 8'(y * 8 + x + 1 + 64 * c + f);
  endfunction

  function automatic logic [31:0] elem(input logic [TILE_W-1:0] d, input int c, input int r, input int k);
    return 32'(d[((c * T + r) * T + k) * W +: W]);
  endfunction

  task automatic check_tile(input int i, input int f, input int spot);
    int b = (i % 9) / 3;
    int t = i % 3;
    int bad = 0;
    logic [TILE_W-1:0] d = fi.tile_data;
    check("tile_row", 32'(fi.tile_row), 32'(b));
    check("tile_col", 32'(fi.tile_col), 32'(t));
    check("last_tile", 32'(fi.last_tile), 32'(i % 9 == 8));
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < T; r++)
        for (int k = 0; k < T; k++)
          if (elem(d, c, r, k) !== 32'(pix(f, b * 2 + r, t * 2 + k, c))) bad++;
    check("tile_data_bad_elems", 32'(bad), 0);
    if (spot == 1) begin
      case (i)
        0: begin
          check("t00_c0_r0k0", elem(d, 0, 0, 0), 1);
          check("t00_c0_r0k3", elem(d, 0, 0, 3), 4);
          check("t00_c0_r1k0", elem(d, 0, 1, 0), 9);
          check("t00_c0_r2k3", elem(d, 0, 2, 3), 20);
          check("t00_c0_r3k3", elem(d, 0, 3, 3), 28);
          check("t00_c2_e0", elem(d, 2, 0, 0), 129);
        end
        1: begin
          check("t01_c0_r0k0", elem(d, 0, 0, 0), 3);
          check("t01_c0_r0k3", elem(d, 0, 0, 3), 6);
        end
        3: begin
          check("t10_c0_r0k0", elem(d, 0, 0, 0), 17);
          check("t10_c0_r0k3", elem(d, 0, 0, 3), 20);
        end
        8: begin
          check("t22_c0_r3k0", elem(d, 0, 3, 0), 61);
          check("t22_c0_r3k3", elem(d, 0, 3, 3), 64);
          check("t22_last", 32'(fi.last_tile), 1);
        end
        default: ;
      endcase
    end else if (spot == 2 && i == 9) begin
      check("f1_t00_c0_r0k0", elem(d, 0, 0, 0), 2);
      check("f1_t00_c0_r0k3", elem(d, 0, 0, 3), 5);
    end
  endtask

  task automatic feed(input int npix, input int f, input bit rnd);
    int n = 0;
    int guard = 0;
    bit v;
    bit acc;
    while (n < npix && guard < 20000) begin
      @(negedge clk);
      guard++;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fi.in_valid = v;
      fi.in_pixel = {pix(f, n / 8, n % 8, 2), pix(f, n / 8, n % 8, 1), pix(f, n / 8, n % 8, 0)};
      acc = v && fi.in_ready;
      if (acc && n == 31 && acc32_edge < 0) acc32_edge = cyc + 1;
      @(posedge clk);
      if (acc) n++;
    end
    if (n < npix) check("feed_timeout", 32'(n), 32'(npix));
    @(negedge clk);
    fi.in_valid = 1'b0;
  endtask

  task automatic sink(input int ntiles, input int f0, input bit rnd, input bit stall, input int spot);
    int got = 0;
    int guard = 0;
    bit rdy;
    bit stalled = 0;
    bit chk_next = 0;
    logic [TILE_W-1:0] snap;
    while (got < ntiles && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (fi.in_ready && fi.tile_valid) overlap_cnt++;
      if (fi.tile_valid && first_valid_edge < 0) first_valid_edge = cyc;
      if (chk_next) begin
        check("post_stall_valid", 32'(fi.tile_valid), 1);
        check("post_stall_col", 32'(fi.tile_col), 2);
        chk_next = 0;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && !stalled && fi.tile_valid && fi.tile_row == 0 && fi.tile_col == 1) begin
        stalled = 1;
        snap = fi.tile_data;
        fi.tile_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("stall_valid", 32'(fi.tile_valid), 1);
          check("stall_data_held", 32'(fi.tile_data == snap), 1);
          check("stall_row", 32'(fi.tile_row), 0);
          check("stall_col", 32'(fi.tile_col), 1);
        end
        @(negedge clk);
        rdy = 1'b1;
        chk_next = 1;
      end
      fi.tile_ready = rdy;
      if (fi.tile_valid && rdy) begin
        check_tile(got, f0 + got / 9, spot);
        got++;
      end
    end
    if (got < ntiles) check("sink_timeout", 32'(got), 32'(ntiles));
  endtask

  initial begin
    reset = 1'b1;
    fi.in_valid = 1'b0;
    fi.in_pixel = '0;
    fi.tile_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(fi.in_ready), 1);
    check("rst_tile_valid", 32'(fi.tile_valid), 0);
    check("rst_last_tile", 32'(fi.last_tile), 0);
    check("rst_tile_row", 32'(fi.tile_row), 0);
    check("rst_tile_col", 32'(fi.tile_col), 0);
    check("rst_tile_data_zero", 32'(fi.tile_data == '0), 1);
    reset = 1'b0;

    // Frame with in_valid held high and tile_ready always high.
    fork
      feed(64, 0, 1'b0);
      sink(9, 0, 1'b0, 1'b0, 1);
    join
    repeat (4) @(negedge clk);
    check("no_extra_tile", 32'(fi.tile_valid), 0);
    check("first_tile_latency", 32'(first_valid_edge - acc32_edge), 1);

    // Backpressure on tile (0,1).
    fork
      feed(64, 0, 1'b0);
      sink(9, 0, 1'b0, 1'b1, 0);
    join

    // Reset in the middle of band 1 fill, then a clean frame.
    fork
      feed(40, 0, 1'b0);
      sink(3, 0, 1'b0, 1'b0, 0);
    join
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(fi.in_ready), 1);
    check("mid_rst_tile_valid", 32'(fi.tile_valid), 0);
    fork
      feed(64, 0, 1'b0);
      sink(9, 0, 1'b0, 1'b0, 1);
    join

    // Two frames back to back, second offset by one.
    fork
      begin
        feed(64, 0, 1'b0);
        feed(64, 1, 1'b0);
      end
      sink(18, 0, 1'b0, 1'b0, 2);
    join

    // Random gaps on both ports.
    fork
      feed(64, 0, 1'b1);
      sink(9, 0, 1'b1, 1'b0, 0);
    join
    repeat (4) @(negedge clk);
    check("rand_no_extra_tile", 32'(fi.tile_valid), 0);
    check("no_fill_emit_overlap", 32'(overlap_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
